dtcm_ctrl: RTL and testbench



---
 rtl/dtcm_ctrl_if.sv | 30 +++
 rtl/dtcm_ctrl.sv | 99 +++++++++
 tb/tb_dtcm_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dtcm_ctrl_if.sv
// LSU-to-DTCM command/response bundle: one command channel, one response channel.
// No storage; pure wiring between the LSU (master) and the DTCM responder (slave).
// Both channels use valid/ready; the master owns cmd valid and rsp ready.
interface dtcm_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic              dtcm_cmd_valid;
  logic              dtcm_cmd_ready;
  logic              dtcm_cmd_read;
  logic [AW-1:0]     dtcm_cmd_addr;
  logic [DW-1:0]     dtcm_cmd_wdata;
  logic [DW/8-1:0]   dtcm_cmd_wmask;
  logic              dtcm_rsp_valid;
  logic              dtcm_rsp_ready;
  logic [DW-1:0]     dtcm_rsp_rdata;
  logic              dtcm_rsp_err;

  modport master (
    output dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr, dtcm_cmd_wdata, dtcm_cmd_wmask,
    output dtcm_rsp_ready,
    input  dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata, dtcm_rsp_err
  );

  modport slave (
    input  dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr, dtcm_cmd_wdata, dtcm_cmd_wmask,
    input  dtcm_rsp_ready,
    output dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata, dtcm_rsp_err
  );
endinterface

// File: rtl/dtcm_ctrl.sv
// Single-port data TCM responder: byte-masked writes, word reads, range error.
// Latency: response registered one cycle after command acceptance.
// Backpressure: cmd_ready drops while a response is held and rsp_ready is low.
module dtcm_ctrl #(
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input logic         clk,
  input logic         rst,
  dtcm_ctrl_if.slave  bus
);

  localparam int MW = DW / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic [AW-3:0]   widx;
  logic [IW-1:0]   midx;
  logic            in_range;
  logic            rsp_valid;
  logic            cmd_ready;
  logic            cmd_hsk;
  logic            rsp_hsk;
  logic            unused_addr_lsb;

  // Word index decode; the two byte-offset bits carry no meaning for a word port
  assign widx            = bus.dtcm_cmd_addr[AW-1:2];
  assign midx            = widx[IW-1:0];
  assign in_range        = ({2'b00, widx} < AW'(DEPTH));
  assign unused_addr_lsb = ^bus.dtcm_cmd_addr[1:0];

  // A command presented during reset must not be accepted or touch the array
  assign cmd_hsk = bus.dtcm_cmd_valid & cmd_ready & ~rst;
  assign rsp_hsk = rsp_valid & bus.dtcm_rsp_ready;

  // Response-slot state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Response-slot next state: a new accept always refills the slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (cmd_hsk) state_d = FULL;
      FULL:    if (rsp_hsk && !cmd_hsk) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs: ready only when the single response slot can be freed this cycle
  always_comb begin
    rsp_valid              = (state_q == FULL);
    cmd_ready              = ~rsp_valid | bus.dtcm_rsp_ready;
    bus.dtcm_rsp_valid     = rsp_valid;
    bus.dtcm_cmd_ready     = cmd_ready;
    bus.dtcm_rsp_rdata     = rdata_q;
    bus.dtcm_rsp_err       = err_q;
  end

  // Response payload: loaded only on accept, so a stalled response stays bit-stable
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (cmd_hsk) begin
      err_d   = ~in_range;
      rdata_d = (bus.dtcm_cmd_read && in_range) ? mem_q[midx] : '0;
    end
  end

  // Response payload register
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Word array: no reset so contents survive rst; per-lane byte enables
  always_ff @(posedge clk) begin
    if (cmd_hsk && !bus.dtcm_cmd_read && in_range) begin
      for (int i = 0; i < MW; i++) begin
        if (bus.dtcm_cmd_wmask[i]) mem_q[midx][8*i +: 8] <= bus.dtcm_cmd_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dtcm_ctrl.sv
module tb_dtcm_ctrl;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dtcm_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  dtcm_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t          sb_q[$];
  logic [DW-1:0] model [DEPTH];
  int            vectors     = 0;
  int            miscompares = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, sample #1 later, score against the model
  task automatic step(input bit r, input bit v, input bit rd, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [3:0] wm, input bit rr);
    logic  exp_ready;
    rsp_t  e;
    int    w;
    @(negedge clk);
    rst                = r;
    bus.dtcm_cmd_valid = v;
    bus.dtcm_cmd_read  = rd;
    bus.dtcm_cmd_addr  = a;
    bus.dtcm_cmd_wdata = wd;
    bus.dtcm_cmd_wmask = wm;
    bus.dtcm_rsp_ready = rr;
    #1;
    chk("rsp_valid", {31'b0, bus.dtcm_rsp_valid}, {31'b0, sb_q.size() != 0});
    exp_ready = (sb_q.size() == 0) || rr;
    chk("cmd_ready", {31'b0, bus.dtcm_cmd_ready}, {31'b0, exp_ready});
    if (sb_q.size() != 0) begin
      chk("rsp_rdata", bus.dtcm_rsp_rdata, sb_q[0].rdata);
      chk("rsp_err", {31'b0, bus.dtcm_rsp_err}, {31'b0, sb_q[0].err});
      if (rr) void'(sb_q.pop_front());
    end
    if (r) begin
      sb_q.delete();
    end else if (v && exp_ready) begin
      w = int'(a[AW-1:2]);
      e.err   = (w >= DEPTH);
      e.rdata = '0;
      if (!e.err) begin
        if (rd) e.rdata = model[w];
        else for (int i = 0; i < 4; i++) if (wm[i]) model[w][8*i +: 8] = wd[8*i +: 8];
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input bit rr);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0, rr);
  endtask

  initial begin
    bus.dtcm_cmd_valid = 1'b0;
    bus.dtcm_cmd_read  = 1'b0;
    bus.dtcm_cmd_addr  = '0;
    bus.dtcm_cmd_wdata = '0;
    bus.dtcm_cmd_wmask = '0;
    bus.dtcm_rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_valid", {31'b0, bus.dtcm_rsp_valid}, 32'd0);
    chk("reset_rdata", bus.dtcm_rsp_rdata, 32'd0);
    chk("reset_err", {31'b0, bus.dtcm_rsp_err}, 32'd0);
    chk("reset_ready", {31'b0, bus.dtcm_cmd_ready}, 32'd1);

    // Full-word write then read, then byte-lane write and read with low address bits set
    step(0, 1, 0, 16'h0010, 32'hDEADBEEF, 4'hF, 1);
    step(0, 1, 1, 16'h0010, 32'h0, 4'h0, 1);
    step(0, 1, 0, 16'h0010, 32'h000000AA, 4'h1, 1);
    step(0, 1, 1, 16'h0013, 32'h0, 4'h0, 1);
    idle(1);
    chk("byte_lane_model", model[4], 32'hDEADBEAA);

    // Zero-mask write leaves word unchanged but still responds
    step(0, 1, 0, 16'h0010, 32'h55555555, 4'h0, 1);
    step(0, 1, 1, 16'h0010, 32'h0, 4'h0, 1);

    // Stall: read response held 3 cycles while a write waits
    step(0, 1, 1, 16'h0010, 32'h0, 4'h0, 1);
    repeat (3) step(0, 1, 0, 16'h0010, 32'h11111111, 4'hF, 0);
    step(0, 1, 0, 16'h0010, 32'h11111111, 4'hF, 1);
    step(0, 1, 1, 16'h0010, 32'h0, 4'h0, 1);
    idle(1);

    // Fill 8 consecutive words, then stream 8 reads back-to-back
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, AW'(16'h0040 + 4 * i), 32'hA5000000 | (32'(i) * 32'h01010101), 4'hF, 1);
    for (int i = 0; i < 8; i++)
      step(0, 1, 1, AW'(16'h0040 + 4 * i), 32'h0, 4'h0, 1);
    idle(1);

    // Out of range at word DEPTH; word 0 must be untouched
    step(0, 1, 0, 16'h0000, 32'h12345678, 4'hF, 1);
    step(0, 1, 1, 16'h1000, 32'h0, 4'h0, 1);
    step(0, 1, 0, 16'h1000, 32'hFFFFFFFF, 4'hF, 1);
    step(0, 1, 1, 16'h0000, 32'h0, 4'h0, 1);
    step(0, 1, 1, 16'hFFFC, 32'h0, 4'h0, 1);
    idle(1);

    // Reset while a response is stalled; a write during reset must not land
    step(0, 1, 1, 16'h0010, 32'h0, 4'h0, 1);
    step(0, 0, 1, 16'h0010, 32'h0, 4'h0, 0);
    step(1, 1, 0, 16'h0010, 32'hBAD0BAD0, 4'hF, 0);
    step(0, 0, 1, 16'h0000, 32'h0, 4'h0, 1);
    step(0, 1, 1, 16'h0010, 32'h0, 4'h0, 1);
    idle(1);
    chk("post_reset_word", model[4], 32'h11111111);

    idle(1);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
